dti_serialize: RTL
==================

// Module: dti_serialize
// PURPOSE
//   Width-down converter on the DTI stream, placed directly downstream of fifo.
//   Accepts one DIN-wide word and emits it as RATIO chunks of DIN/RATIO bits, LSB chunk first.
//   Used where a wide buffered stream must feed a narrow consumer (bus, serial link, narrow ALU).
//   Full throughput: one chunk per cycle, no bubbles between consecutive words.
// PARAMETERS
//   DIN    16  input word width in bits
//   RATIO  4   chunks per word; DIN % RATIO must be 0, else $error at elaboration; RATIO >= 1
//   CHUNK  DIN/RATIO  localparam, chunk width in bits
//   CW     max(1,$clog2(RATIO))  localparam, chunk counter width
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      synchronous reset, ACTIVE-LOW (rst==0 resets)
//   din        dti.consumer  DIN          wide word stream (data/valid/ready)
//   dout       dti.producer  CHUNK(+1)    narrow chunk stream; +1 bit only with SERIALIZE_EOT_EN
// BEHAVIOUR
//   - State: buf_reg[DIN-1:0], cnt_reg[CW-1:0], busy_reg (IDLE = !busy, BUSY = busy).
//   - Reset (rst==0 at posedge): busy_reg=0, cnt_reg=0; buf_reg not reset.
//     While rst==0: din.ready=0, dout.valid=0.
//   - dout.valid = busy_reg; dout.data = buf_reg[cnt_reg*CHUNK +: CHUNK]; purely from registers.
//   - last = (cnt_reg == RATIO-1).
//   - din.ready = !busy_reg | (last & dout.ready).
//   - din handshake (din.valid & din.ready): buf_reg<=din.data, cnt_reg<=0, busy_reg<=1.
//   - dout handshake, !last: cnt_reg<=cnt_reg+1.
//   - dout handshake, last, no din handshake: busy_reg<=0, cnt_reg<=0.
//   - dout handshake, last, with din handshake: reload as above, busy stays 1 (back-to-back).
//   - Latency: first chunk valid 1 cycle after din handshake; a word occupies exactly RATIO
//     cycles of dout under dout.ready=1.
//   - Backpressure: dout.ready=0 holds dout.data/valid stable and cnt_reg frozen.
//     din.ready=0 while busy and not (last & dout.ready).
//   - dout.valid never depends combinationally on dout.ready; din.ready depends on dout.ready
//     only in BUSY at last chunk.
//   - RATIO==1: last always 1, block degenerates to a 1-deep pipeline register at full rate.
//   - Reset mid-word: in-flight word discarded, no further chunks of it emitted.
//     First din.ready=1 in the first cycle with rst==1.
//   - Counter never exceeds RATIO-1; no wrap for non-power-of-2 RATIO.
// CONFIGURATION
//   SERIALIZE_EOT_EN defined:
//     - dout.data width CHUNK+1.
//     - Bit [CHUNK] = last (end-of-word flag), 1 only on final chunk of each word.
//   SERIALIZE_EOT_EN undefined:
//     - dout.data width CHUNK; no flag; otherwise identical timing.
// TESTING
//   1 Reset: hold rst=0 3 cycles with din.valid=1
//     -> dout.valid=0, din.ready=0 throughout; din.ready=1 first cycle rst=1.
//   2 DIN=16 RATIO=4, dout.ready=1, din words 0xABCD then 0x1234 back-to-back
//     -> dout chunks D,C,B,A,4,3,2,1 on 8 consecutive cycles, no bubble.
//     -> din.ready=1 on the cycle chunk A is emitted.
//   3 Backpressure: during 0xABCD, dout.ready=0 for 3 cycles while chunk C shown
//     -> dout.data=C, dout.valid=1 stable, din.ready=0; resumes with B, A.
//   4 Reset mid-word: rst=0 one cycle after chunk C accepted
//     -> dout.valid=0 next cycle, B/A never appear; next word 0x5678 emits 8,7,6,5.
//   5 SERIALIZE_EOT_EN, word 0xABCD -> dout.data = {0,D},{0,C},{0,B},{1,A}.
//   6 RATIO=1 DIN=8, random valid/ready 1000 words
//     -> output sequence equals input sequence.
//     -> 1-cycle latency; 1 word/cycle when both sides are always ready.

Source files
------------

// File: rtl/dti_serialize.sv
// Width-down converter: one DIN-bit word in, RATIO chunks of DIN/RATIO bits out, LSB chunk first.
// Optional end-of-word flag on dout_data[CHUNK] when SERIALIZE_EOT_EN is defined.
module dti_serialize #(
  parameter int DIN   = 16,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIN-1:0]         din_data,
  input  logic                   din_valid,
  output logic                   din_ready,
`ifdef SERIALIZE_EOT_EN
  output logic [DIN/RATIO:0]     dout_data,
`else
  output logic [DIN/RATIO-1:0]   dout_data,
`endif
  output logic                   dout_valid,
  input  logic                   dout_ready
);

  localparam int CHUNK = DIN / RATIO;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (RATIO < 1) begin : g_bad_ratio
      $error("dti_serialize: RATIO must be >= 1");
    end else if (DIN % RATIO != 0) begin : g_bad_div
      $error("dti_serialize: DIN must be a multiple of RATIO");
    end
  endgenerate

  logic [DIN-1:0] buf_q, buf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  logic             last;
  logic             din_fire;
  logic             dout_fire;
  logic [CHUNK-1:0] chunk;

  assign last  = (cnt_q == CW'(RATIO - 1));
  assign chunk = buf_q[int'(cnt_q)*CHUNK +: CHUNK];

  // Both handshakes are masked while rst is low so nothing is accepted or emitted in reset.
  assign dout_valid = rst & busy_q;
  assign din_ready  = rst & (~busy_q | (last & dout_ready));
  assign din_fire   = din_valid & din_ready;
  assign dout_fire  = dout_valid & dout_ready;

`ifdef SERIALIZE_EOT_EN
  assign dout_data = {last, chunk};
`else
  assign dout_data = chunk;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (dout_fire) begin
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // A load on the last chunk's handshake overrides the drain above, giving back-to-back words.
    if (din_fire) begin
      buf_d  = din_data;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: the data buffer carries no reset; busy_q alone decides whether its contents are visible.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule
